// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: command, comp_unit, host-load and status signals of the
// exec_sequencer. The slave modport is the sequencer's view; master is the
// surrounding logic (decoder, comp_unit, regfile, response logic).
interface exec_sequencer_if;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned DATA_W = 32;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [REG_W-1:0]  cmd_rs1;
  logic [REG_W-1:0]  cmd_rs2;
  logic [REG_W-1:0]  cmd_rd;
  logic [IMM_W-1:0]  cmd_imm;
  logic [REG_W-1:0]  rf_rs1_addr;
  logic [REG_W-1:0]  rf_rs2_addr;
  logic              cu_start;
  logic [OP_W-1:0]   cu_op;
  logic [IMM_W-1:0]  cu_imm;
  logic              cu_done;
  logic [DATA_W-1:0] cu_result;
  logic              host_wr_req;
  logic [REG_W-1:0]  host_wr_addr;
  logic [DATA_W-1:0] host_wr_data;
  logic              host_wr_grant;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;
  logic              done_pulse;
  logic              err_illegal;
  logic              err_timeout;
  logic              err_clr;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm,
    input  cu_done, cu_result, host_wr_req, host_wr_addr, host_wr_data, err_clr,
    output cmd_ready, rf_rs1_addr, rf_rs2_addr, cu_start, cu_op, cu_imm,
    output host_wr_grant, rf_we, rf_waddr, rf_wdata, busy, done_pulse,
    output err_illegal, err_timeout
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm,
    output cu_done, cu_result, host_wr_req, host_wr_addr, host_wr_data, err_clr,
    input  cmd_ready, rf_rs1_addr, rf_rs2_addr, cu_start, cu_op, cu_imm,
    input  host_wr_grant, rf_we, rf_waddr, rf_wdata, busy, done_pulse,
    input  err_illegal, err_timeout
  );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: in-order command sequencer between the AXI write decoder and
// the regfile/comp_unit pair. Buffers commands in a FIFO, issues them to
// comp_unit one at a time, and shares the regfile write port with host loads.
// Optional macro EXEC_SEQ_WATCHDOG_EN adds an EXEC-state watchdog that aborts
// a hung op and raises err_timeout; without it err_timeout is tied low.
module exec_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_OPS    = 10,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_aresetn,
  exec_sequencer_if.slave    bus
);
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WDOG_W = 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  // Elaboration-time parameter sanity checks
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("exec_sequencer: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (NUM_OPS < 1 || NUM_OPS > 16) begin : g_bad_num_ops
    $error("exec_sequencer: NUM_OPS must be in 1..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("exec_sequencer: TIMEOUT must fit the 8-bit watchdog (1..255)");
  end

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  cmd_t              fifo_mem [FIFO_DEPTH];
  cmd_t              cmd_in;
  cmd_t              head;
  cmd_t              work_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              head_illegal;
  state_t            state;
  state_t            state_nxt;
  logic              load_work;
  logic              latch_result;
  logic              set_illegal;
  logic              cu_start_c;
  logic [DATA_W-1:0] result_q;
  logic              host_prev_q;
  logic              host_grant;
  logic              seq_grant;
  logic              err_illegal_q;

`ifdef EXEC_SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_expire;
  logic              set_timeout;
  logic              err_timeout_q;

  assign wdog_expire = (wdog_cnt == WDOG_W'(TIMEOUT - 1));
`endif

  assign cmd_in = '{op: bus.cmd_op, rs1: bus.cmd_rs1, rs2: bus.cmd_rs2,
                    rd: bus.cmd_rd, imm: bus.cmd_imm};
  assign head         = fifo_mem[rd_ptr];
  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign push         = bus.cmd_valid && !full;
  assign pop          = (state == ST_IDLE) && !empty;
  assign head_illegal = (32'(head.op) >= NUM_OPS);

  // Write-port arbitration: host by default, sequencer after a host grant
  always_comb begin
    host_grant = bus.host_wr_req && !(host_prev_q && (state == ST_WB));
    seq_grant  = (state == ST_WB) && !host_grant;
  end

  // Next-state and per-state controls
  always_comb begin
    state_nxt    = state;
    load_work    = 1'b0;
    latch_result = 1'b0;
    set_illegal  = 1'b0;
    cu_start_c   = 1'b0;
`ifdef EXEC_SEQ_WATCHDOG_EN
    set_timeout  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          if (head_illegal) begin
            set_illegal = 1'b1;
          end else begin
            load_work = 1'b1;
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cu_start_c = 1'b1;
        state_nxt  = ST_EXEC;
      end
      ST_EXEC: begin
        if (bus.cu_done) begin
          latch_result = 1'b1;
          state_nxt    = ST_WB;
        end
`ifdef EXEC_SEQ_WATCHDOG_EN
        else if (wdog_expire) begin
          set_timeout = 1'b1;
          state_nxt   = ST_IDLE;
        end
`endif
      end
      ST_WB: begin
        if (seq_grant) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, FIFO pointers, working registers and sticky error flag
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= ST_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      work_q        <= '0;
      result_q      <= '0;
      host_prev_q   <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      host_prev_q <= host_grant;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (load_work)    work_q   <= head;
      if (latch_result) result_q <= bus.cu_result;
      if (set_illegal)      err_illegal_q <= 1'b1;
      else if (bus.err_clr) err_illegal_q <= 1'b0;
    end
  end

  // Command storage; contents are qualified by the pointers, so no reset
  always_ff @(posedge s_axi_aclk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

`ifdef EXEC_SEQ_WATCHDOG_EN
  // Watchdog: restarts as EXEC is entered, counts each EXEC cycle
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wdog_cnt      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (state == ST_ISSUE)     wdog_cnt <= '0;
      else if (state == ST_EXEC) wdog_cnt <= wdog_cnt + WDOG_W'(1);
      if (set_timeout)      err_timeout_q <= 1'b1;
      else if (bus.err_clr) err_timeout_q <= 1'b0;
    end
  end

  assign bus.err_timeout = err_timeout_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.cmd_ready     = !full;
  assign bus.rf_rs1_addr   = work_q.rs1;
  assign bus.rf_rs2_addr   = work_q.rs2;
  assign bus.cu_op         = work_q.op;
  assign bus.cu_imm        = work_q.imm;
  assign bus.cu_start      = cu_start_c;
  assign bus.host_wr_grant = host_grant;
  assign bus.rf_we         = host_grant || seq_grant;
  assign bus.rf_waddr      = host_grant ? bus.host_wr_addr :
                             (seq_grant ? work_q.rd : '0);
  assign bus.rf_wdata      = host_grant ? bus.host_wr_data :
                             (seq_grant ? result_q : '0);
  assign bus.busy          = !empty || (state != ST_IDLE);
  assign bus.done_pulse    = seq_grant;
  assign bus.err_illegal   = err_illegal_q;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a transaction-level model.
module tb_exec_sequencer;
  localparam int DEPTH   = 4;
  localparam int NUM_OPS = 10;
  localparam int TIMEOUT = 255;

  typedef struct {
    int op;
    int rs1;
    int rs2;
    int rd;
    int imm;
  } mcmd_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exec_sequencer_if bus ();

  exec_sequencer #(.FIFO_DEPTH(DEPTH), .NUM_OPS(NUM_OPS), .TIMEOUT(TIMEOUT)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  mcmd_t       m_q[$];
  mcmd_t       m_cur;
  bit          m_live;
  bit          m_start;
  bit          m_res_v;
  logic [31:0] m_res;
  bit          m_host_last;
  bit          m_ill;
  bit          m_to;
  int          m_wait;

  always @(negedge clk) begin
    bit wb_want, e_hg, e_sw, pushed, ill_set, to_set;
    mcmd_t h;
    #1;
    if (!rst_n) begin
      m_q.delete();
      m_live = 0; m_start = 0; m_res_v = 0; m_host_last = 0;
      m_ill = 0; m_to = 0; m_wait = 0;
      chk("rst_ready", 32'(bus.cmd_ready), 1);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_we", 32'(bus.rf_we), 0);
      chk("rst_start", 32'(bus.cu_start), 0);
      chk("rst_done", 32'(bus.done_pulse), 0);
      chk("rst_err", 32'({bus.err_illegal, bus.err_timeout}), 0);
    end else begin
      wb_want = m_live && m_res_v;
      e_hg    = bus.host_wr_req && !(m_host_last && wb_want);
      e_sw    = wb_want && !e_hg;
      chk("ready", 32'(bus.cmd_ready), 32'(m_q.size() < DEPTH));
      chk("busy", 32'(bus.busy), 32'(m_q.size() != 0 || m_live));
      chk("cu_start", 32'(bus.cu_start), 32'(m_live && m_start));
      if (m_live && !m_res_v) begin
        chk("cu_op", 32'(bus.cu_op), m_cur.op);
        chk("cu_imm", 32'(bus.cu_imm), m_cur.imm);
        chk("rs1", 32'(bus.rf_rs1_addr), m_cur.rs1);
        chk("rs2", 32'(bus.rf_rs2_addr), m_cur.rs2);
      end
      chk("host_grant", 32'(bus.host_wr_grant), 32'(e_hg));
      chk("rf_we", 32'(bus.rf_we), 32'(e_hg || e_sw));
      chk("done_pulse", 32'(bus.done_pulse), 32'(e_sw));
      if (e_hg) begin
        chk("waddr_host", 32'(bus.rf_waddr), 32'(bus.host_wr_addr));
        chk("wdata_host", bus.rf_wdata, bus.host_wr_data);
      end else if (e_sw) begin
        chk("waddr_seq", 32'(bus.rf_waddr), m_cur.rd);
        chk("wdata_seq", bus.rf_wdata, m_res);
      end
      chk("err_illegal", 32'(bus.err_illegal), 32'(m_ill));
      chk("err_timeout", 32'(bus.err_timeout), 32'(m_to));

      // advance the model by one clock
      pushed  = bus.cmd_valid && (m_q.size() < DEPTH);
      ill_set = 0;
      to_set  = 0;
      if (!m_live) begin
        if (m_q.size() != 0) begin
          h = m_q.pop_front();
          if (h.op >= NUM_OPS) ill_set = 1;
          else begin
            m_cur = h; m_live = 1; m_start = 1;
          end
        end
      end else if (m_start) begin
        m_start = 0;
        m_wait  = 0;
      end else if (!m_res_v) begin
        if (bus.cu_done) begin
          m_res = bus.cu_result;
          m_res_v = 1;
        end
`ifdef EXEC_SEQ_WATCHDOG_EN
        else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_live = 0;
            to_set = 1;
          end
        end
`endif
      end else if (e_sw) begin
        m_live = 0;
        m_res_v = 0;
      end
      if (pushed)
        m_q.push_back('{int'(bus.cmd_op), int'(bus.cmd_rs1), int'(bus.cmd_rs2),
                        int'(bus.cmd_rd), int'(bus.cmd_imm)});
      m_ill = ill_set ? 1'b1 : (bus.err_clr ? 1'b0 : m_ill);
      m_to  = to_set  ? 1'b1 : (bus.err_clr ? 1'b0 : m_to);
      m_host_last = e_hg;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_rs1 = 0; bus.cmd_rs2 = 0;
    bus.cmd_rd = 0; bus.cmd_imm = 0; bus.cu_done = 0; bus.cu_result = 0;
    bus.host_wr_req = 0; bus.host_wr_addr = 0; bus.host_wr_data = 0; bus.err_clr = 0;
  endtask

  task automatic set_cmd(input int op, input int rs1, input int rs2, input int rd, input int imm);
    bus.cmd_valid = 1;
    bus.cmd_op  = 4'(op);
    bus.cmd_rs1 = 5'(rs1);
    bus.cmd_rs2 = 5'(rs2);
    bus.cmd_rd  = 5'(rd);
    bus.cmd_imm = 16'(imm);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bus.cmd_valid = 0; bus.host_wr_req = 0; bus.cu_done = 1; bus.err_clr = 0;
    forever begin
      @(negedge clk);
      bus.cu_result = $urandom;
      #2;
      if (!bus.busy || n >= budget) break;
      n++;
    end
    chk("drain_idle", 32'(bus.busy), 0);
    bus.cu_done = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #2;
    chk("reset_ready", 32'(bus.cmd_ready), 1);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_waddr", 32'(bus.rf_waddr), 0);
    rst_n = 1;

    // single op: accepted T, start T+2, done T+3, writeback T+4
    @(negedge clk); set_cmd(1, 2, 3, 4, 'h0010);
    @(negedge clk); bus.cmd_valid = 0;
    @(negedge clk); #2;
    chk("single_start", 32'(bus.cu_start), 1);
    chk("single_rs1", 32'(bus.rf_rs1_addr), 2);
    chk("single_rs2", 32'(bus.rf_rs2_addr), 3);
    chk("single_op", 32'(bus.cu_op), 1);
    chk("single_imm", 32'(bus.cu_imm), 'h10);
    @(negedge clk); bus.cu_done = 1; bus.cu_result = 32'hDEADBEEF; #2;
    chk("single_exec_start", 32'(bus.cu_start), 0);
    chk("single_exec_rs1", 32'(bus.rf_rs1_addr), 2);
    @(negedge clk); bus.cu_done = 0; #2;
    chk("single_we", 32'(bus.rf_we), 1);
    chk("single_waddr", 32'(bus.rf_waddr), 4);
    chk("single_wdata", bus.rf_wdata, 32'hDEADBEEF);
    chk("single_done", 32'(bus.done_pulse), 1);
    @(negedge clk); #2;
    chk("single_busy_after", 32'(bus.busy), 0);

    // FIFO full: one op stalled in EXEC, then five pushes
    @(negedge clk); set_cmd(3, 1, 1, 5, 7);
    @(negedge clk); bus.cmd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_cmd(i, i, i + 1, 10 + i, i * 3);
    end
    @(negedge clk); set_cmd(4, 4, 5, 14, 12); #2;
    chk("full_ready_low", 32'(bus.cmd_ready), 0);
    repeat (2) @(negedge clk);
    bus.cu_done = 1; bus.cu_result = 32'h1111_2222;
    @(negedge clk); bus.cu_done = 0;
    @(negedge clk); #2;
    chk("full_ready_at_pop", 32'(bus.cmd_ready), 0);
    @(negedge clk); #2;
    chk("full_ready_after_pop", 32'(bus.cmd_ready), 1);
    @(negedge clk); bus.cmd_valid = 0;
    drain(80);

    // arbitration: host request appears as the sequencer enters WB
    @(negedge clk); set_cmd(5, 1, 1, 9, 0);
    @(negedge clk); bus.cmd_valid = 0;
    @(negedge clk);
    @(negedge clk); bus.cu_done = 1; bus.cu_result = 32'hCAFEF00D;
    @(negedge clk); bus.cu_done = 0;
    bus.host_wr_req = 1; bus.host_wr_addr = 5'd7; bus.host_wr_data = 32'h1234_5678; #2;
    chk("arb1_grant", 32'(bus.host_wr_grant), 1);
    chk("arb1_waddr", 32'(bus.rf_waddr), 7);
    chk("arb1_wdata", bus.rf_wdata, 32'h1234_5678);
    chk("arb1_done", 32'(bus.done_pulse), 0);
    @(negedge clk); #2;
    chk("arb2_grant", 32'(bus.host_wr_grant), 0);
    chk("arb2_we", 32'(bus.rf_we), 1);
    chk("arb2_waddr", 32'(bus.rf_waddr), 9);
    chk("arb2_wdata", bus.rf_wdata, 32'hCAFEF00D);
    chk("arb2_done", 32'(bus.done_pulse), 1);
    @(negedge clk); #2;
    chk("arb3_grant", 32'(bus.host_wr_grant), 1);
    chk("arb3_waddr", 32'(bus.rf_waddr), 7);
    @(negedge clk); bus.host_wr_req = 0;

    // illegal op followed by a legal one
    @(negedge clk); set_cmd(12, 1, 2, 3, 0);
    @(negedge clk); set_cmd(2, 6, 7, 8, 0); #2;
    chk("ill_before", 32'(bus.err_illegal), 0);
    @(negedge clk); bus.cmd_valid = 0; #2;
    chk("ill_set", 32'(bus.err_illegal), 1);
    chk("ill_no_start", 32'(bus.cu_start), 0);
    @(negedge clk); #2;
    chk("ill_next_start", 32'(bus.cu_start), 1);
    chk("ill_next_op", 32'(bus.cu_op), 2);
    drain(20);
    @(negedge clk); bus.err_clr = 1;
    @(negedge clk); bus.err_clr = 0; #2;
    chk("ill_cleared", 32'(bus.err_illegal), 0);

    // reset while an op is in EXEC with two queued behind it
    @(negedge clk); set_cmd(1, 1, 1, 1, 1);
    @(negedge clk); set_cmd(2, 2, 2, 2, 2);
    @(negedge clk); set_cmd(3, 3, 3, 3, 3);
    @(negedge clk); bus.cmd_valid = 0;
    @(negedge clk); #3;
    rst_n = 0;
    idle_inputs();
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_ready", 32'(bus.cmd_ready), 1);
    chk("arst_start", 32'(bus.cu_start), 0);
    chk("arst_op", 32'(bus.cu_op), 0);
    chk("arst_rs1", 32'(bus.rf_rs1_addr), 0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus.cu_done = 1; bus.cu_result = $urandom; #2;
      chk("post_rst_we", 32'(bus.rf_we), 0);
    end
    bus.cu_done = 0;

`ifdef EXEC_SEQ_WATCHDOG_EN
    begin
      int n;
      @(negedge clk); set_cmd(4, 1, 2, 3, 4);
      @(negedge clk); set_cmd(6, 5, 6, 7, 8);
      @(negedge clk); bus.cmd_valid = 0;
      n = 0;
      while (!bus.cu_start && n < 10) begin @(negedge clk); #2; n++; end
      chk("wd_first_start", 32'(bus.cu_start), 1);
      n = 0;
      while (!bus.err_timeout && n < 400) begin @(negedge clk); #2; n++; end
      chk("wd_cycles", 32'(n), 256);
      @(negedge clk); #2;
      chk("wd_next_start", 32'(bus.cu_start), 1);
      chk("wd_next_op", 32'(bus.cu_op), 6);
      drain(20);
      @(negedge clk); bus.err_clr = 1;
      @(negedge clk); bus.err_clr = 0;
    end
`endif

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.cmd_valid    = ($urandom_range(0, 1) == 1);
      bus.cmd_op       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      bus.cmd_rs1      = 5'($urandom);
      bus.cmd_rs2      = 5'($urandom);
      bus.cmd_rd       = 5'($urandom);
      bus.cmd_imm      = 16'($urandom);
      bus.cu_done      = ($urandom_range(0, 9) < 4);
      bus.cu_result    = $urandom;
      bus.host_wr_req  = ($urandom_range(0, 1) == 1);
      bus.host_wr_addr = 5'($urandom);
      bus.host_wr_data = $urandom;
      bus.err_clr      = ($urandom_range(0, 15) == 0);
    end
    drain(80);
    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
